jk_toggle_monitor: RTL and testbench

Checker and statistics stage directly downstream of the behavioural JK flip-flop. It samples the flip-flop's command inputs (j, k) and outputs (q, q_bar) on the same clock and predicts the next q from the JK truth table. It flags illegal or mispredicted outputs, counts output toggles and emits edge pulses. It is used both as an in-design health monitor and as a self-checking probe in the flip-flop benches.

---
 rtl/jk_toggle_monitor.sv | 167 ++++++++++++++++
 tb/tb_jk_toggle_monitor.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/jk_toggle_monitor.sv
// jk_toggle_monitor: checker and statistics stage for a JK flip-flop.
// Predicts the next q from the sampled (j, k, q), flags illegal or
// mispredicted outputs, counts q changes and emits edge pulses.
// Optional feature macro: JK_TOGGLE_MONITOR_STUCK_EN enables the stuck
// counter; when undefined, `stuck` is tied low and STUCK_LIMIT is unused.
module jk_toggle_monitor #(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned STUCK_LIMIT = 16
) (
  input  logic             en,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             j,
  input  logic             k,
  input  logic             q,
  input  logic             q_bar,
  output logic [CNT_W-1:0] toggle_cnt,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic             err_compl,
  output logic             err_mode,
  output logic             stuck,
  output logic [1:0]       mon_state
);

  typedef enum logic [1:0] {
    ST_INIT  = 2'b00,
    ST_TRACK = 2'b01,
    ST_FAULT = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Elaboration-time guard on parameter legality.
  if (CNT_W < 2 || CNT_W > 16) begin : g_bad_cnt_w
    $error("jk_toggle_monitor: CNT_W must be within 2..16");
  end
  if (STUCK_LIMIT < 2 || STUCK_LIMIT > (2 ** CNT_W) - 1) begin : g_bad_stuck_limit
    $error("jk_toggle_monitor: STUCK_LIMIT must be within 2..2^CNT_W-1");
  end

  state_t           state_q, state_nxt;
  logic             q_d, j_d, k_d;
  logic [CNT_W-1:0] cnt_nxt;
  logic             rise_nxt, fall_nxt;
  logic             err_compl_nxt, err_mode_nxt;
  logic             q_pred_c;
  logic             q_chg_c;
  logic             active_c;

  assign q_chg_c   = (q != q_d);
  assign active_c  = (state_q != ST_INIT);
  assign mon_state = state_q;

  // JK truth table applied to the previous-cycle samples.
  always_comb begin
    q_pred_c = q_d;
    case ({j_d, k_d})
      2'b00:   q_pred_c = q_d;
      2'b01:   q_pred_c = 1'b0;
      2'b10:   q_pred_c = 1'b1;
      default: q_pred_c = ~q_d;
    endcase
  end

  // Next-state, checks, edge detection and saturating toggle count.
  always_comb begin
    state_nxt     = state_q;
    cnt_nxt       = toggle_cnt;
    rise_nxt      = 1'b0;
    fall_nxt      = 1'b0;
    err_compl_nxt = err_compl;
    err_mode_nxt  = err_mode;
    if (clr) begin
      state_nxt     = ST_INIT;
      cnt_nxt       = '0;
      err_compl_nxt = 1'b0;
      err_mode_nxt  = 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          state_nxt = ST_TRACK;
        end
        ST_TRACK: begin
          if (q != q_pred_c) begin
            err_mode_nxt = 1'b1;
            state_nxt    = ST_FAULT;
          end
          if (q == q_bar) begin
            err_compl_nxt = 1'b1;
          end
        end
        ST_FAULT: begin
          if (q == q_bar) begin
            err_compl_nxt = 1'b1;
          end
        end
        default: begin
          state_nxt = ST_INIT;
        end
      endcase
      if (active_c && q_chg_c) begin
        if (toggle_cnt != CNT_MAX) begin
          cnt_nxt = toggle_cnt + CNT_W'(1);
        end
        rise_nxt = q;
        fall_nxt = ~q;
      end
    end
  end

  // State, history and registered outputs.
  always_ff @(posedge en or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_INIT;
      q_d        <= 1'b0;
      j_d        <= 1'b0;
      k_d        <= 1'b0;
      toggle_cnt <= '0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      err_compl  <= 1'b0;
      err_mode   <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      q_d        <= q;
      j_d        <= j;
      k_d        <= k;
      toggle_cnt <= cnt_nxt;
      rise_pulse <= rise_nxt;
      fall_pulse <= fall_nxt;
      err_compl  <= err_compl_nxt;
      err_mode   <= err_mode_nxt;
    end
  end

`ifdef JK_TOGGLE_MONITOR_STUCK_EN
  localparam int unsigned STK_W = $clog2(STUCK_LIMIT + 1);
  localparam logic [STK_W-1:0] STK_MAX = STK_W'(STUCK_LIMIT);

  logic [STK_W-1:0] stk_cnt, stk_nxt;

  // Count cycles of a toggle command that produced no q change.
  always_comb begin
    stk_nxt = stk_cnt;
    if (clr || !active_c || !(j_d && k_d) || q_chg_c) begin
      stk_nxt = '0;
    end else if (stk_cnt != STK_MAX) begin
      stk_nxt = stk_cnt + STK_W'(1);
    end
  end

  // Stuck counter and its registered limit flag.
  always_ff @(posedge en or negedge rst_n) begin
    if (!rst_n) begin
      stk_cnt <= '0;
      stuck   <= 1'b0;
    end else begin
      stk_cnt <= stk_nxt;
      stuck   <= (stk_nxt == STK_MAX);
    end
  end
`else
  assign stuck = 1'b0;
`endif

endmodule

// File: tb/tb_jk_toggle_monitor.sv
// Directed bench for jk_toggle_monitor: a default instance (CNT_W=8,
// STUCK_LIMIT=16) and a narrow instance (CNT_W=2, STUCK_LIMIT=3) share stimulus.
module tb_jk_toggle_monitor;

  logic       en;
  logic       rst_n;
  logic       clr;
  logic       j;
  logic       k;
  logic       q;
  logic       q_bar;
  logic [7:0] toggle_cnt;
  logic       rise_pulse;
  logic       fall_pulse;
  logic       err_compl;
  logic       err_mode;
  logic       stuck;
  logic [1:0] mon_state;
  logic [1:0] s_toggle_cnt;
  logic       s_rise_pulse;
  logic       s_fall_pulse;
  logic       s_err_compl;
  logic       s_err_mode;
  logic       s_stuck;
  logic [1:0] s_mon_state;

  logic       qm;
  int         n_cmp;
  int         n_bad;

`ifdef JK_TOGGLE_MONITOR_STUCK_EN
  localparam logic STUCK_EXP = 1'b1;
`else
  localparam logic STUCK_EXP = 1'b0;
`endif

  jk_toggle_monitor #(.CNT_W(8), .STUCK_LIMIT(16)) u_dut (
    .en(en), .rst_n(rst_n), .clr(clr), .j(j), .k(k), .q(q), .q_bar(q_bar),
    .toggle_cnt(toggle_cnt), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
    .err_compl(err_compl), .err_mode(err_mode), .stuck(stuck),
    .mon_state(mon_state)
  );

  jk_toggle_monitor #(.CNT_W(2), .STUCK_LIMIT(3)) u_sat (
    .en(en), .rst_n(rst_n), .clr(clr), .j(j), .k(k), .q(q), .q_bar(q_bar),
    .toggle_cnt(s_toggle_cnt), .rise_pulse(s_rise_pulse), .fall_pulse(s_fall_pulse),
    .err_compl(s_err_compl), .err_mode(s_err_mode), .stuck(s_stuck),
    .mon_state(s_mon_state)
  );

  initial en = 1'b0;
  always #5 en = ~en;

  function automatic logic jk_next(input logic qq, input logic jj, input logic kk);
    case ({jj, kk})
      2'b00:   return qq;
      2'b01:   return 1'b0;
      2'b10:   return 1'b1;
      default: return ~qq;
    endcase
  endfunction

  // Apply one cycle of inputs, then sample 1 time unit after the edge.
  task automatic step(input logic jj, input logic kk, input logic qq, input logic qqb);
    j = jj; k = kk; q = qq; q_bar = qqb;
    @(posedge en);
    #1;
  endtask

  // One cycle driven by a correct flip-flop model.
  task automatic cyc(input logic jj, input logic kk);
    step(jj, kk, qm, ~qm);
    qm = jk_next(qm, jj, kk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; clr = 1'b0;
    j = 1'b0; k = 1'b0; q = 1'b0; q_bar = 1'b1; qm = 1'b0;
    repeat (2) @(posedge en);
    @(negedge en);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (mon_state !== 2'b00) begin n_bad++; $display("FAIL reset_init_state: got %b expected 00", mon_state); end
    cyc(1'b0, 1'b0);
    n_cmp++; if (mon_state !== 2'b01) begin n_bad++; $display("FAIL reset_to_track: got %b expected 01", mon_state); end
    repeat (5) cyc(1'b1, 1'b1);
    cyc(1'b0, 1'b0);
    n_cmp++; if (toggle_cnt !== 8'd5) begin n_bad++; $display("FAIL reset_pre_cnt: got %0d expected 5", toggle_cnt); end
    n_cmp++; if (rise_pulse !== 1'b1) begin n_bad++; $display("FAIL reset_pre_rise: got %b expected 1", rise_pulse); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (toggle_cnt !== 8'd0) begin n_bad++; $display("FAIL reset_async_cnt: got %0d expected 0", toggle_cnt); end
    n_cmp++; if ({rise_pulse, fall_pulse, err_compl, err_mode, stuck} !== 5'b0)
      begin n_bad++; $display("FAIL reset_async_flags: got %b expected 00000", {rise_pulse, fall_pulse, err_compl, err_mode, stuck}); end
    n_cmp++; if (mon_state !== 2'b00) begin n_bad++; $display("FAIL reset_async_state: got %b expected 00", mon_state); end
    @(negedge en);
    rst_n = 1'b1; qm = 1'b0;
    #1;
    n_cmp++; if (mon_state !== 2'b00) begin n_bad++; $display("FAIL reset_release_state: got %b expected 00", mon_state); end
    cyc(1'b0, 1'b0);
    n_cmp++; if (mon_state !== 2'b01) begin n_bad++; $display("FAIL reset_release_track: got %b expected 01", mon_state); end
  endtask

  task automatic test_toggle();
    int nr, nf, snr, snf;
    nr = 0; nf = 0; snr = 0; snf = 0;
    do_reset();
    cyc(1'b0, 1'b0);
    for (int i = 0; i < 11; i++) begin
      if (i < 10) cyc(1'b1, 1'b1);
      else        cyc(1'b0, 1'b0);
      if (rise_pulse)   nr++;
      if (fall_pulse)   nf++;
      if (s_rise_pulse) snr++;
      if (s_fall_pulse) snf++;
    end
    n_cmp++; if (toggle_cnt !== 8'd10) begin n_bad++; $display("FAIL toggle_cnt: got %0d expected 10", toggle_cnt); end
    n_cmp++; if (nr !== 5) begin n_bad++; $display("FAIL toggle_rise: got %0d expected 5", nr); end
    n_cmp++; if (nf !== 5) begin n_bad++; $display("FAIL toggle_fall: got %0d expected 5", nf); end
    n_cmp++; if (err_mode !== 1'b0) begin n_bad++; $display("FAIL toggle_err_mode: got %b expected 0", err_mode); end
    n_cmp++; if (mon_state !== 2'b01) begin n_bad++; $display("FAIL toggle_state: got %b expected 01", mon_state); end
    n_cmp++; if (s_toggle_cnt !== 2'd3) begin n_bad++; $display("FAIL sat_cnt: got %0d expected 3", s_toggle_cnt); end
    n_cmp++; if (snr !== 5 || snf !== 5) begin n_bad++; $display("FAIL sat_pulses: got rise %0d fall %0d expected 5 5", snr, snf); end
  endtask

  task automatic test_sequence();
    do_reset();
    cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    n_cmp++; if ({rise_pulse, fall_pulse} !== 2'b10) begin n_bad++; $display("FAIL seq_set_pulse: got %b expected 10", {rise_pulse, fall_pulse}); end
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b0);
    n_cmp++; if ({rise_pulse, fall_pulse} !== 2'b01) begin n_bad++; $display("FAIL seq_reset_pulse: got %b expected 01", {rise_pulse, fall_pulse}); end
    cyc(1'b0, 1'b0);
    n_cmp++; if (toggle_cnt !== 8'd2) begin n_bad++; $display("FAIL seq_cnt: got %0d expected 2", toggle_cnt); end
    n_cmp++; if ({err_compl, err_mode} !== 2'b00) begin n_bad++; $display("FAIL seq_errs: got %b expected 00", {err_compl, err_mode}); end
    n_cmp++; if (mon_state !== 2'b01) begin n_bad++; $display("FAIL seq_state: got %b expected 01", mon_state); end
  endtask

  task automatic test_mode_err();
    do_reset();
    cyc(1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    n_cmp++; if (err_mode !== 1'b1) begin n_bad++; $display("FAIL mode_err_set: got %b expected 1", err_mode); end
    n_cmp++; if (mon_state !== 2'b10) begin n_bad++; $display("FAIL mode_fault_state: got %b expected 10", mon_state); end
    n_cmp++; if (err_compl !== 1'b0) begin n_bad++; $display("FAIL mode_no_compl: got %b expected 0", err_compl); end
    step(1'b0, 1'b0, 1'b1, 1'b0);
    n_cmp++; if ({mon_state, err_mode, toggle_cnt} !== {2'b10, 1'b1, 8'd1})
      begin n_bad++; $display("FAIL mode_fault_hold: got st %b em %b cnt %0d expected 10 1 1", mon_state, err_mode, toggle_cnt); end
    clr = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b1);
    clr = 1'b0;
    n_cmp++; if (mon_state !== 2'b00) begin n_bad++; $display("FAIL clr_state: got %b expected 00", mon_state); end
    n_cmp++; if (err_mode !== 1'b0) begin n_bad++; $display("FAIL clr_err_mode: got %b expected 0", err_mode); end
    n_cmp++; if ({toggle_cnt, fall_pulse} !== {8'd0, 1'b0}) begin n_bad++; $display("FAIL clr_priority: got cnt %0d fall %b expected 0 0", toggle_cnt, fall_pulse); end
    qm = 1'b0;
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    n_cmp++; if (mon_state !== 2'b01) begin n_bad++; $display("FAIL clr_retrack: got %b expected 01", mon_state); end
  endtask

  task automatic test_compl();
    do_reset();
    cyc(1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    n_cmp++; if (err_compl !== 1'b1) begin n_bad++; $display("FAIL compl_set: got %b expected 1", err_compl); end
    n_cmp++; if ({mon_state, err_mode} !== {2'b01, 1'b0}) begin n_bad++; $display("FAIL compl_track: got st %b em %b expected 01 0", mon_state, err_mode); end
    n_cmp++; if ({toggle_cnt, rise_pulse} !== {8'd1, 1'b1}) begin n_bad++; $display("FAIL compl_rise: got cnt %0d rise %b expected 1 1", toggle_cnt, rise_pulse); end
    step(1'b0, 1'b0, 1'b1, 1'b0);
    n_cmp++; if ({err_compl, mon_state} !== {1'b1, 2'b01}) begin n_bad++; $display("FAIL compl_sticky: got ec %b st %b expected 1 01", err_compl, mon_state); end
  endtask

  task automatic test_stuck();
    do_reset();
    cyc(1'b0, 1'b0);
    repeat (16) step(1'b1, 1'b1, 1'b0, 1'b1);
    n_cmp++; if (stuck !== 1'b0) begin n_bad++; $display("FAIL stuck_early: got %b expected 0", stuck); end
    step(1'b1, 1'b1, 1'b0, 1'b1);
    n_cmp++; if (stuck !== STUCK_EXP) begin n_bad++; $display("FAIL stuck_limit: got %b expected %b", stuck, STUCK_EXP); end
    n_cmp++; if (s_stuck !== STUCK_EXP) begin n_bad++; $display("FAIL stuck_narrow: got %b expected %b", s_stuck, STUCK_EXP); end
    n_cmp++; if ({mon_state, err_mode} !== {2'b10, 1'b1}) begin n_bad++; $display("FAIL stuck_fault: got st %b em %b expected 10 1", mon_state, err_mode); end
    step(1'b1, 1'b1, 1'b1, 1'b0);
    n_cmp++; if ({stuck, s_stuck} !== 2'b00) begin n_bad++; $display("FAIL stuck_clear: got %b expected 00", {stuck, s_stuck}); end
    n_cmp++; if (rise_pulse !== 1'b1) begin n_bad++; $display("FAIL stuck_fault_pulse: got %b expected 1", rise_pulse); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_toggle();
    test_sequence();
    test_mode_err();
    test_compl();
    test_stuck();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
